// File: rtl/instr_sequencer_if.sv
// Decoder, memory-handshake and write-back strobes shared between the sequencer
// and the rest of the vector core.
interface instr_sequencer_if #(
    parameter int CNT_W = 5,
    parameter int EW    = 4
);
    logic             imem_req;
    logic             imem_rdy;
    logic             instr_ld;
    logic [3:0]       functype;
    logic [CNT_W-1:0] cycle_count;
    logic             v_en;
    logic             s_en;
    logic [7:0]       immediate;
    logic             exec_valid;
    logic [EW-1:0]    elem_idx;
    logic             dmem_req;
    logic             dmem_we;
    logic             dmem_rdy;
    logic             v_we;
    logic             s_we;

    modport master (
        output imem_req, instr_ld, exec_valid, elem_idx, dmem_req, dmem_we, v_we, s_we,
        input  imem_rdy, functype, cycle_count, v_en, s_en, immediate, dmem_rdy
    );

    modport slave (
        input  imem_req, instr_ld, exec_valid, elem_idx, dmem_req, dmem_we, v_we, s_we,
        output imem_rdy, functype, cycle_count, v_en, s_en, immediate, dmem_rdy
    );
endinterface

// File: rtl/instr_sequencer.sv
// Top-level control FSM of the CVP14 vector core: fetch, decode, multi-beat
// execute with memory handshakes, and write-back with PC update.
module instr_sequencer #(
    parameter int PC_W      = 16,
    parameter int NUM_ELEMS = 16,
    parameter int CNT_W     = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    input  logic              halt_req,
    output logic [PC_W-1:0]   pc,
    output logic              busy,
    output logic              halted,
    instr_sequencer_if.master bus
);
    localparam int EW = $clog2(NUM_ELEMS);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [3:0] OP_VLD = 4'd4;
    localparam logic [3:0] OP_VST = 4'd5;
    localparam logic [3:0] OP_J   = 4'd8;

    logic [2:0]       state;
    logic [CNT_W-1:0] beat_cnt;
    logic [CNT_W-1:0] beats;
    logic             mem_op;
    logic             op_defined;
    logic             advance;
    logic             last_beat;

    function automatic logic [PC_W-1:0] next_pc(input logic [PC_W-1:0] cur,
                                                 input logic jump,
                                                 input logic signed [7:0] offs);
        logic signed [PC_W-1:0] ext;
        ext = jump ? {{(PC_W-8){offs[7]}}, offs} : '0;
        return cur + PC_W'(1) + ext;
    endfunction

    always_comb begin
        mem_op         = (bus.functype == OP_VLD) || (bus.functype == OP_VST);
        op_defined     = (bus.functype <= OP_J);
        advance        = !mem_op || bus.dmem_rdy;
        last_beat      = (beat_cnt == beats - CNT_W'(1));
        bus.imem_req   = (state == S_FETCH);
        bus.instr_ld   = (state == S_FETCH) && bus.imem_rdy;
        bus.exec_valid = (state == S_EXEC);
        bus.elem_idx   = (state == S_EXEC) ? beat_cnt[EW-1:0] : '0;
        bus.dmem_req   = (state == S_EXEC) && mem_op;
        bus.dmem_we    = (state == S_EXEC) && (bus.functype == OP_VST);
        // NOP and undefined opcodes reach WB but must not touch the register files
        bus.v_we       = (state == S_WB) && bus.v_en && op_defined;
        bus.s_we       = (state == S_WB) && bus.s_en && op_defined;
        busy           = (state != S_IDLE) && (state != S_HALT);
        halted         = (state == S_HALT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            pc       <= '0;
            beat_cnt <= '0;
            beats    <= '0;
        end else begin
            case (state)
                S_IDLE:   if (go) state <= S_FETCH;
                S_FETCH:  if (bus.imem_rdy) state <= S_DECODE;
                S_DECODE: begin
                    beats    <= (bus.cycle_count == '0) ? CNT_W'(1) : bus.cycle_count;
                    beat_cnt <= '0;
                    state    <= op_defined ? S_EXEC : S_WB;
                end
                S_EXEC: begin
                    if (advance) begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                        if (last_beat) state <= S_WB;
                    end
                end
                S_WB: begin
                    pc    <= next_pc(pc, bus.functype == OP_J, bus.immediate);
                    state <= halt_req ? S_HALT : S_FETCH;
                end
                S_HALT:   state <= S_HALT;
                default:  state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: each instruction is expanded into a
// per-cycle expected trace that a single negedge process compares against.
module tb_instr_sequencer;
    typedef struct {
        logic       rst, go, halt, imem_rdy, dmem_rdy;
        logic [3:0] ft;
        logic [4:0] cc;
        logic       ve, se;
        logic [7:0] imm;
    } stim_t;

    typedef struct {
        bit          chk;
        int          cyc;
        logic [15:0] pc;
        logic        imem_req, instr_ld, exec_valid;
        logic [3:0]  idx;
        logic        dmem_req, dmem_we, v_we, s_we, busy, halted;
    } exp_t;

    typedef struct {
        string name;
        int    act;
        int    req;
    } lit_t;

    logic        clk;
    logic        rst;
    logic        go;
    logic        halt_req;
    logic [15:0] pc;
    logic        busy;
    logic        halted;

    instr_sequencer_if bus ();

    instr_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .go       (go),
        .halt_req (halt_req),
        .pc       (pc),
        .busy     (busy),
        .halted   (halted),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t        exp_q[$];
    lit_t        lit_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc_ctr = 0;
    int          exec_cnt = 0;
    int          vwe_cnt = 0;
    int          dwe_cnt = 0;
    int          vwe_cyc = 0;
    logic [15:0] m_pc = 16'h0000;
    int          mode = 0;  // 0 idle, 1 running, 2 halted

    function automatic stim_t base_stim();
        stim_t s;
        s.rst = 1'b0; s.go = 1'b0; s.halt = 1'b0; s.imem_rdy = 1'b0; s.dmem_rdy = 1'b0;
        s.ft = 4'hF; s.cc = 5'd0; s.ve = 1'b0; s.se = 1'b0; s.imm = 8'h00;
        return s;
    endfunction

    function automatic exp_t idle_exp();
        exp_t e;
        e.chk = 1'b1; e.cyc = 0; e.pc = m_pc;
        e.imem_req = 1'b0; e.instr_ld = 1'b0; e.exec_valid = 1'b0; e.idx = 4'd0;
        e.dmem_req = 1'b0; e.dmem_we = 1'b0; e.v_we = 1'b0; e.s_we = 1'b0;
        e.busy = 1'b0; e.halted = (mode == 2);
        return e;
    endfunction

    task automatic step(input stim_t s, input exp_t e);
        @(posedge clk);
        #1;
        rst             = s.rst;
        go              = s.go;
        halt_req        = s.halt;
        bus.imem_rdy    = s.imem_rdy;
        bus.dmem_rdy    = s.dmem_rdy;
        bus.functype    = s.ft;
        bus.cycle_count = s.cc;
        bus.v_en        = s.ve;
        bus.s_en        = s.se;
        bus.immediate   = s.imm;
        cyc_ctr++;
        e.cyc = cyc_ctr;
        exp_q.push_back(e);
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic lit(input string name, input int act, input int req);
        lit_t l;
        l.name = name; l.act = act; l.req = req;
        lit_q.push_back(l);
    endtask

    task automatic do_reset(input int n);
        stim_t s;
        exp_t  e;
        mode = 0;
        m_pc = 16'h0000;
        s = base_stim();
        s.rst = 1'b1;
        for (int i = 0; i < n; i++) begin
            e = idle_exp();
            e.chk = (i > 0);
            step(s, e);
        end
    endtask

    task automatic hold(input int n, input logic g);
        stim_t s;
        s = base_stim();
        s.go = g;
        for (int i = 0; i < n; i++) step(s, idle_exp());
    endtask

    task automatic start();
        stim_t s;
        s = base_stim();
        s.go = 1'b1;
        step(s, idle_exp());
        mode = 1;
    endtask

    task automatic run_instr(input logic [3:0] ft, input logic [4:0] cc, input logic ve,
                             input logic se, input logic [7:0] imm, input int fetch_wait,
                             input int stall_a, input int stall_b, input int stall_n,
                             input logic halt_exec, input logic halt_wb, input int abort_at);
        stim_t s;
        exp_t  e, b;
        int    beats, st, n, t;
        bit    defined, mem;
        defined = (ft <= 4'd8);
        mem     = (ft == 4'd4) || (ft == 4'd5);
        s = base_stim();
        s.ft = ft; s.cc = cc; s.ve = ve; s.se = se; s.imm = imm;
        b = idle_exp();
        b.busy = 1'b1;
        b.halted = 1'b0;
        for (int i = 0; i < fetch_wait; i++) begin
            e = b; e.imem_req = 1'b1;
            step(s, e);
        end
        s.imem_rdy = 1'b1;
        e = b; e.imem_req = 1'b1; e.instr_ld = 1'b1;
        step(s, e);
        s.imem_rdy = 1'b0;
        step(s, b);
        if (defined) begin
            beats = (cc == 5'd0) ? 1 : int'(cc);
            n = 0;
            for (int k = 0; k < beats; k++) begin
                st = (mem && (k == stall_a || k == stall_b)) ? stall_n : 0;
                for (int w = 0; w <= st; w++) begin
                    s.dmem_rdy = mem && (w == st);
                    s.halt     = halt_exec;
                    e = b;
                    e.exec_valid = 1'b1;
                    e.idx        = k[3:0];
                    e.dmem_req   = mem;
                    e.dmem_we    = (ft == 4'd5);
                    step(s, e);
                    n++;
                    if (abort_at >= 0 && n == abort_at) return;
                end
            end
        end
        s.dmem_rdy = 1'b0;
        s.halt = halt_wb;
        e = b; e.v_we = ve && defined; e.s_we = se && defined;
        step(s, e);
        t = int'(m_pc) + 1 + ((ft == 4'd8) ? int'($signed(imm)) : 0);
        m_pc = t[15:0];
        mode = halt_wb ? 2 : 1;
    endtask

    always @(negedge clk) begin
        exp_t        e;
        lit_t        l;
        logic [12:0] got, want;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (bus.exec_valid === 1'b1) exec_cnt++;
            if (bus.dmem_we === 1'b1) dwe_cnt++;
            if (bus.v_we === 1'b1) begin
                vwe_cnt++;
                vwe_cyc = e.cyc;
            end
            if (e.chk) begin
                got  = {bus.imem_req, bus.instr_ld, bus.exec_valid, bus.elem_idx, bus.dmem_req,
                        bus.dmem_we, bus.v_we, bus.s_we, busy, halted};
                want = {e.imem_req, e.instr_ld, e.exec_valid, e.idx, e.dmem_req,
                        e.dmem_we, e.v_we, e.s_we, e.busy, e.halted};
                n_checks++;
                if (got !== want) begin
                    n_errors++;
                    $display("FAIL cyc%0d ctrl got=%b want=%b (imem_req,instr_ld,exec_valid,elem_idx[4],dmem_req,dmem_we,v_we,s_we,busy,halted)",
                             e.cyc, got, want);
                end
                n_checks++;
                if (pc !== e.pc) begin
                    n_errors++;
                    $display("FAIL cyc%0d pc got=%h want=%h", e.cyc, pc, e.pc);
                end
            end
        end
        while (lit_q.size() > 0) begin
            l = lit_q.pop_front();
            n_checks++;
            if (l.act != l.req) begin
                n_errors++;
                $display("FAIL %s got=%0d want=%0d", l.name, l.act, l.req);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, ex0, vw0, dw0;
        rst = 1'b1; go = 1'b0; halt_req = 1'b0;
        bus.imem_rdy = 1'b0; bus.dmem_rdy = 1'b0; bus.functype = 4'hF;
        bus.cycle_count = 5'd0; bus.v_en = 1'b0; bus.s_en = 1'b0; bus.immediate = 8'h00;

        do_reset(2);
        settle();
        lit("reset_busy", int'(busy), 0);
        lit("reset_pc", int'(pc), 0);

        // VADD, single beat, v_we on cycle 4 counting FETCH as cycle 1
        start();
        settle();
        c0 = cyc_ctr; vw0 = vwe_cnt;
        run_instr(4'd0, 5'd1, 1'b1, 1'b0, 8'h00, 0, -1, -1, 0, 1'b0, 1'b0, -1);
        settle();
        lit("vadd_vwe_count", vwe_cnt - vw0, 1);
        lit("vadd_vwe_cycle", vwe_cyc - c0, 4);
        lit("vadd_model_pc", int'(m_pc), 1);

        // reset in the middle of a VLD execute phase
        run_instr(4'd4, 5'd16, 1'b1, 1'b0, 8'h00, 0, -1, -1, 0, 1'b0, 1'b0, 5);
        do_reset(2);
        settle();
        lit("rst_mid_pc", int'(pc), 0);
        lit("rst_mid_dmem_req", int'(bus.dmem_req), 0);
        lit("rst_mid_exec_valid", int'(bus.exec_valid), 0);
        lit("rst_mid_busy", int'(busy), 0);

        start();
        settle();
        ex0 = exec_cnt; vw0 = vwe_cnt; dw0 = dwe_cnt;
        run_instr(4'd4, 5'd16, 1'b1, 1'b0, 8'h00, 0, 3, 7, 2, 1'b0, 1'b0, -1);
        settle();
        lit("vld_exec_cycles", exec_cnt - ex0, 20);
        lit("vld_dmem_we", dwe_cnt - dw0, 0);
        lit("vld_vwe", vwe_cnt - vw0, 1);

        ex0 = exec_cnt; vw0 = vwe_cnt; dw0 = dwe_cnt;
        run_instr(4'd5, 5'd15, 1'b0, 1'b0, 8'h00, 2, -1, -1, 0, 1'b0, 1'b0, -1);
        settle();
        lit("vst_exec_cycles", exec_cnt - ex0, 15);
        lit("vst_dmem_we", dwe_cnt - dw0, 15);
        lit("vst_vwe", vwe_cnt - vw0, 0);
        lit("vst_model_pc", int'(m_pc), 2);

        // NOP with v_en set must still produce no strobe; SMUL with cycle_count 0 runs one beat
        run_instr(4'hF, 5'd3, 1'b1, 1'b1, 8'h00, 1, -1, -1, 0, 1'b0, 1'b0, -1);
        run_instr(4'd2, 5'd0, 1'b0, 1'b1, 8'h00, 0, -1, -1, 0, 1'b0, 1'b0, -1);
        settle();
        lit("smul_model_pc", int'(m_pc), 4);

        run_instr(4'd8, 5'd1, 1'b0, 1'b0, 8'hF9, 0, -1, -1, 0, 1'b0, 1'b0, -1);
        settle();
        lit("j_back_model_pc", int'(m_pc), 16'hFFFE);
        run_instr(4'd8, 5'd1, 1'b0, 1'b0, 8'h05, 0, -1, -1, 0, 1'b0, 1'b0, -1);
        settle();
        lit("j_wrap_model_pc", int'(m_pc), 16'h0004);
        run_instr(4'd8, 5'd1, 1'b0, 1'b0, 8'h0B, 0, -1, -1, 0, 1'b0, 1'b0, -1);
        settle();
        lit("j_fwd_model_pc", int'(m_pc), 16'h0010);
        run_instr(4'd8, 5'd1, 1'b0, 1'b0, 8'hFE, 0, -1, -1, 0, 1'b0, 1'b0, -1);
        settle();
        lit("j_neg_model_pc", int'(m_pc), 16'h000F);

        // halt_req only during EXEC is ignored; held in WB it halts
        run_instr(4'd0, 5'd2, 1'b1, 1'b0, 8'h00, 0, -1, -1, 0, 1'b1, 1'b0, -1);
        run_instr(4'd3, 5'd2, 1'b0, 1'b1, 8'h00, 0, -1, -1, 0, 1'b0, 1'b1, -1);
        hold(3, 1'b1);
        settle();
        lit("halt_halted", int'(halted), 1);
        lit("halt_busy", int'(busy), 0);
        lit("halt_pc", int'(pc), 16'h0011);

        do_reset(2);
        hold(2, 1'b0);
        settle();
        lit("post_halt_reset_halted", int'(halted), 0);
        settle();
        settle();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
